tracer_rx_channel: RTL
======================

# tracer_rx_channel

Receive-side transfer engine of the trace debugger's uDMA peripheral. It consumes the channel configuration driven by the register interface: start address, size, data size, continuous mode, and the enable/clear pulses. It accepts a valid/ready stream of packed trace words from the packetizer and issues L2 write requests, one per beat. It reports channel enable, pending, current address and bytes left back to the register interface for readback, and pulses an end-of-transfer event.

## Interface
- L2_AWIDTH_NOAL, 12, L2 byte-address width
- TRANS_SIZE, 16, transfer byte-count width
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- cfg_startaddr_i  in  L2_AWIDTH_NOAL  start byte address
- cfg_size_i  in  TRANS_SIZE  transfer length in bytes
- cfg_datasize_i  in  2  beat size: 00 byte, 01 half, 10 word, 11 treated as word
- cfg_continuous_i  in  1  reload start/size at end of transfer
- cfg_en_i  in  1  single-cycle enable pulse
- cfg_clr_i  in  1  single-cycle abort pulse
- cfg_en_o  out  1  channel active
- cfg_pending_o  out  1  queued transfer present
- cfg_curr_addr_o  out  L2_AWIDTH_NOAL  next write address
- cfg_bytes_left_o  out  TRANS_SIZE  bytes remaining
- data_i  in  32  trace word, beat in low bits
- data_valid_i  in  1  stream valid
- data_ready_o  out  1  stream ready
- l2_req_o  out  1  write request
- l2_gnt_i  in  1  write grant
- l2_addr_o  out  L2_AWIDTH_NOAL  write byte address
- l2_wdata_o  out  32  write data
- l2_be_o  out  4  byte enables
- evt_done_o  out  1  end-of-transfer pulse

## Operation
- FSM states: IDLE, ACTIVE, WRITE.
- IDLE:
  - cfg_en_i with cfg_size_i != 0 loads start address, size, datasize and continuous into working registers, then moves to ACTIVE.
  - cfg_en_i with size 0 is ignored.
- ACTIVE:
  - data_ready_o = 1.
  - On valid&ready, capture data_i and move to WRITE.
- WRITE:
  - l2_req_o = 1; address, data and be are held stable until l2_gnt_i.
  - On grant, curr_addr += inc and bytes_left -= inc, where inc = 1, 2 or 4 per datasize.
  - If bytes_left <= inc, bytes_left becomes 0 (saturating) and the transfer ends; otherwise return to ACTIVE.
- End of transfer:
  - evt_done_o pulses for one cycle.
  - Continuous: reload the saved start and size and go to ACTIVE.
  - Else, if pending: load the pending config and go to ACTIVE.
  - Else: go to IDLE.
- Byte enables and data:
  - Byte: be = 1 << addr[1:0]; wdata = data_i[7:0] replicated ×4.
  - Half: be = 4'b0011 << {addr[1],1'b0}; wdata = data_i[15:0] replicated ×2.
  - Word: be = 4'hF; wdata = data_i.
  - l2_addr_o = curr_addr with addr[1:0] forced to 0.
- cfg_en_o = (state != IDLE).
- cfg_clr_i:
  - In IDLE or ACTIVE: next state is IDLE, pending is cleared, no evt_done_o.
  - In WRITE: the current request completes on grant and counters update, then IDLE; no evt_done_o even if this was the final beat.
  - clr and en in the same cycle: clr wins and en is dropped.
- Reset: all outputs 0, state IDLE, working and pending registers 0.

## Timing
- Stream beat accepted in cycle N → l2_req_o high from cycle N+1 (registered).
- Peak throughput is one beat per 2 cycles with l2_gnt_i tied high.
- l2_gnt_i low holds WRITE indefinitely; data_ready_o stays 0 throughout.
- cfg_curr_addr_o and cfg_bytes_left_o update the cycle after the grant.
- evt_done_o is high in the cycle after the final grant.
- cfg_en_i in IDLE → cfg_en_o = 1 and data_ready_o = 1 the next cycle.
- Address arithmetic wraps modulo 2^L2_AWIDTH_NOAL with no error.
- Continuous reload and start of the next beat happen with no idle cycle: ACTIVE the cycle after the grant.

## Configuration
- TRACER_RX_PENDING_EN defined:
  - cfg_en_i while cfg_en_o = 1 latches cfg_startaddr_i, cfg_size_i, cfg_datasize_i and cfg_continuous_i into a one-deep pending slot and sets cfg_pending_o.
  - A further cfg_en_i while pending overwrites the slot.
  - The slot is consumed at end of a non-continuous transfer.
- Not defined:
  - cfg_en_i while active is ignored.
  - cfg_pending_o is tied 0 and no pending registers exist.

## Test plan
- Word mode, start 0x100, size 8, gnt tied 1, data 0xAABBCCDD then 0x11223344 → two writes to 0x100 and 0x104 with be=F; bytes_left 4 then 0; evt_done_o one pulse; cfg_en_o drops.
- Byte mode, start 0x101, size 3, data 0x5A → be 0010, 0100, 1000; wdata 0x5A5A5A5A; curr_addr ends at 0x104.
- Word mode, size 6 → second write saturates bytes_left to 0 and ends; gnt held low 5 cycles on the first write → l2_req_o, l2_addr_o and l2_wdata_o stable and data_ready_o = 0 throughout.
- Continuous mode, start 0x200, size 4 → after the grant, evt_done_o pulses, curr_addr returns to 0x200, bytes_left returns to 4, cfg_en_o stays 1.
- cfg_clr_i during WRITE with gnt delayed 3 cycles → request completes, then IDLE with no evt_done_o; cfg_clr_i and cfg_en_i together in IDLE → stays IDLE.
- With TRACER_RX_PENDING_EN: cfg_en_i (start 0x300, size 4) mid-transfer → cfg_pending_o = 1; at end of transfer the channel reloads 0x300 and cfg_pending_o returns to 0. Without the macro, the same stimulus → channel goes to IDLE.

Source files
------------

// File: rtl/tracer_rx_channel.sv
// tracer_rx_channel: receive-side uDMA transfer engine for the trace debugger.
// Takes packed trace beats from a valid/ready stream and writes them to L2,
// one request per beat, tracking address and remaining byte count.
//
// Optional feature macro: TRACER_RX_PENDING_EN
//   defined   -> one-deep pending configuration slot; cfg_en_i while active
//                queues the next transfer, consumed at end of a
//                non-continuous transfer.
//   undefined -> cfg_en_i while active is ignored; cfg_pending_o tied 0.
//
// Handshakes: a stream beat transfers on a rising edge where data_valid_i and
// data_ready_o are both high; an L2 write completes on a rising edge where
// l2_req_o and l2_gnt_i are both high, and address/data/be stay stable while
// l2_req_o is high and l2_gnt_i is low.
module tracer_rx_channel #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  input  logic [31:0]               data_i,
  input  logic                      data_valid_i,
  output logic                      data_ready_o,
  output logic                      l2_req_o,
  input  logic                      l2_gnt_i,
  output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
  output logic [31:0]               l2_wdata_o,
  output logic [3:0]                l2_be_o,
  output logic                      evt_done_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    WRITE  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [L2_AWIDTH_NOAL-1:0] start_q, start_d;
  logic [TRANS_SIZE-1:0]     size_q, size_d;
  logic [1:0]                dsize_q, dsize_d;
  logic                      cont_q, cont_d;
  logic [L2_AWIDTH_NOAL-1:0] addr_q, addr_d;
  logic [TRANS_SIZE-1:0]     left_q, left_d;
  logic [31:0]               data_q, data_d;
  logic                      clr_q, clr_d;    // abort requested while a write is in flight
  logic                      done_q, done_d;

  logic [2:0] inc;
  logic       last_beat;
  logic       en_ok;

  // Beat size in bytes; datasize 11 behaves as a word.
  always_comb begin
    case (dsize_q)
      2'b00:   inc = 3'd1;
      2'b01:   inc = 3'd2;
      default: inc = 3'd4;
    endcase
  end

  // Final beat when the remaining count fits in one beat (saturates to 0).
  assign last_beat = (left_q <= TRANS_SIZE'(inc));
  // Clear always wins over enable; zero-size enables are dropped.
  assign en_ok     = cfg_en_i && !cfg_clr_i && (cfg_size_i != '0);

`ifdef TRACER_RX_PENDING_EN
  logic                      pend_valid_q, pend_valid_d;
  logic [L2_AWIDTH_NOAL-1:0] pend_addr_q, pend_addr_d;
  logic [TRANS_SIZE-1:0]     pend_size_q, pend_size_d;
  logic [1:0]                pend_dsize_q, pend_dsize_d;
  logic                      pend_cont_q, pend_cont_d;
`endif

  // Next-state, working-register and pending-slot update.
  always_comb begin
    state_d = state_q;
    start_d = start_q;
    size_d  = size_q;
    dsize_d = dsize_q;
    cont_d  = cont_q;
    addr_d  = addr_q;
    left_d  = left_q;
    data_d  = data_q;
    clr_d   = clr_q;
    done_d  = 1'b0;
`ifdef TRACER_RX_PENDING_EN
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_size_d  = pend_size_q;
    pend_dsize_d = pend_dsize_q;
    pend_cont_d  = pend_cont_q;
`endif

    case (state_q)
      IDLE: begin
        if (en_ok) begin
          start_d = cfg_startaddr_i;
          size_d  = cfg_size_i;
          dsize_d = cfg_datasize_i;
          cont_d  = cfg_continuous_i;
          addr_d  = cfg_startaddr_i;
          left_d  = cfg_size_i;
          state_d = ACTIVE;
        end
`ifdef TRACER_RX_PENDING_EN
        // A slot filled in the very cycle a transfer ended is started here.
        else if (pend_valid_q && !cfg_clr_i) begin
          start_d      = pend_addr_q;
          size_d       = pend_size_q;
          dsize_d      = pend_dsize_q;
          cont_d       = pend_cont_q;
          addr_d       = pend_addr_q;
          left_d       = pend_size_q;
          pend_valid_d = 1'b0;
          state_d      = ACTIVE;
        end
`endif
      end

      ACTIVE: begin
        if (cfg_clr_i) begin
          state_d = IDLE;
        end else if (data_valid_i) begin
          data_d  = data_i;
          state_d = WRITE;
        end
      end

      WRITE: begin
        if (cfg_clr_i) clr_d = 1'b1;
        if (l2_gnt_i) begin
          addr_d = addr_q + L2_AWIDTH_NOAL'(inc);
          left_d = last_beat ? '0 : (left_q - TRANS_SIZE'(inc));
          clr_d  = 1'b0;
          if (clr_q || cfg_clr_i) begin
            state_d = IDLE;
          end else if (!last_beat) begin
            state_d = ACTIVE;
          end else begin
            done_d = 1'b1;
            if (cont_q) begin
              addr_d  = start_q;
              left_d  = size_q;
              state_d = ACTIVE;
            end
`ifdef TRACER_RX_PENDING_EN
            else if (pend_valid_q) begin
              start_d      = pend_addr_q;
              size_d       = pend_size_q;
              dsize_d      = pend_dsize_q;
              cont_d       = pend_cont_q;
              addr_d       = pend_addr_q;
              left_d       = pend_size_q;
              pend_valid_d = 1'b0;
              state_d      = ACTIVE;
            end
`endif
            else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef TRACER_RX_PENDING_EN
    // Abort drops any queued transfer; a new enable while active (re)fills
    // the slot, after any consumption above so a same-cycle enable survives.
    if (cfg_clr_i) pend_valid_d = 1'b0;
    if (en_ok && (state_q != IDLE) && !clr_q) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = cfg_startaddr_i;
      pend_size_d  = cfg_size_i;
      pend_dsize_d = cfg_datasize_i;
      pend_cont_d  = cfg_continuous_i;
    end
`endif
  end

  // State and working registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      start_q <= '0;
      size_q  <= '0;
      dsize_q <= '0;
      cont_q  <= 1'b0;
      addr_q  <= '0;
      left_q  <= '0;
      data_q  <= '0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      size_q  <= size_d;
      dsize_q <= dsize_d;
      cont_q  <= cont_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      data_q  <= data_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

`ifdef TRACER_RX_PENDING_EN
  // Pending configuration slot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_size_q  <= '0;
      pend_dsize_q <= '0;
      pend_cont_q  <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_size_q  <= pend_size_d;
      pend_dsize_q <= pend_dsize_d;
      pend_cont_q  <= pend_cont_d;
    end
  end
  assign cfg_pending_o = pend_valid_q;
`else
  assign cfg_pending_o = 1'b0;
`endif

  // L2 write lanes: byte/half replicate across the word, be picks the lane.
  always_comb begin
    l2_be_o    = 4'h0;
    l2_wdata_o = '0;
    l2_addr_o  = '0;
    if (state_q == WRITE) begin
      l2_addr_o = {addr_q[L2_AWIDTH_NOAL-1:2], 2'b00};
      case (dsize_q)
        2'b00: begin
          l2_be_o    = 4'b0001 << addr_q[1:0];
          l2_wdata_o = {4{data_q[7:0]}};
        end
        2'b01: begin
          l2_be_o    = 4'b0011 << {addr_q[1], 1'b0};
          l2_wdata_o = {2{data_q[15:0]}};
        end
        default: begin
          l2_be_o    = 4'hF;
          l2_wdata_o = data_q;
        end
      endcase
    end
  end

  assign cfg_en_o         = (state_q != IDLE);
  assign data_ready_o     = (state_q == ACTIVE);
  assign l2_req_o         = (state_q == WRITE);
  assign cfg_curr_addr_o  = addr_q;
  assign cfg_bytes_left_o = left_q;
  assign evt_done_o       = done_q;

endmodule
